// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: synchronised/debounced buttons, LED register, W1C edge events and a maskable irq.
// Define MMIO_GPIO_BOTH_EDGES_EN to also latch release (1->0) edges of the debounced inputs as events.
module mmio_gpio_bank #(
  parameter int NUM_IN          = 16,
  parameter int NUM_OUT         = 16,
  parameter int ADDR_W          = 15,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               write_enable,
  input  logic [15:0]        data_in,
  output logic [15:0]        data_out,
  input  logic [NUM_IN-1:0]  buttons,
  output logic [NUM_OUT-1:0] leds,
  output logic               irq
);

  localparam int B     = NUM_IN + NUM_OUT;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_IN_WORD  = ADDR_W'(B);
  localparam logic [ADDR_W-1:0] ADDR_OUT_WORD = ADDR_W'(B + 1);
  localparam logic [ADDR_W-1:0] ADDR_EVT      = ADDR_W'(B + 2);
  localparam logic [ADDR_W-1:0] ADDR_MASK     = ADDR_W'(B + 3);

  logic [NUM_IN-1:0]  sync1_reg;
  logic [NUM_IN-1:0]  sync2_reg;
  logic [NUM_IN-1:0]  in_db_reg;
  logic [NUM_IN-1:0]  in_db_next;
  logic [NUM_IN-1:0]  in_db_dly_reg;
  logic [NUM_IN-1:0]  accept;
  logic [NUM_IN-1:0]  evt_reg;
  logic [NUM_IN-1:0]  evt_next;
  logic [NUM_IN-1:0]  evt_set;
  logic [NUM_IN-1:0]  evt_clr;
  logic [NUM_IN-1:0]  mask_reg;
  logic [NUM_IN-1:0]  mask_next;
  logic [NUM_OUT-1:0] leds_reg;
  logic [NUM_OUT-1:0] leds_next;
  logic [15:0]        data_out_reg;
  logic [15:0]        rd_data;
  logic [NUM_IN-1:0]  in_bit_hit;
  logic [NUM_OUT-1:0] led_bit_hit;
  logic               hit_in_word;
  logic               hit_out_word;
  logic               hit_evt;
  logic               hit_mask;

  assign hit_in_word  = (addr == ADDR_IN_WORD);
  assign hit_out_word = (addr == ADDR_OUT_WORD);
  assign hit_evt      = (addr == ADDR_EVT);
  assign hit_mask     = (addr == ADDR_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= buttons;
      sync2_reg <= sync1_reg;
    end
  end

  // Counter runs only while sync2 disagrees with the accepted level; the edge on
  // which it would reach DEBOUNCE_CYCLES is the edge that commits the new level.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if ((sync2_reg[gi] == in_db_reg[gi]) || accept[gi]) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign accept[gi]     = (sync2_reg[gi] != in_db_reg[gi]) && (cnt_reg == CNT_LAST);
      assign in_db_next[gi] = accept[gi] ? sync2_reg[gi] : in_db_reg[gi];
      assign in_bit_hit[gi] = (addr == ADDR_W'(gi));
    end

    for (gi = 0; gi < NUM_OUT; gi++) begin : g_led_decode
      assign led_bit_hit[gi] = (addr == ADDR_W'(NUM_IN + gi));
    end
  endgenerate

  // Edges are taken from the delayed copy so events land one edge after in_db.
`ifdef MMIO_GPIO_BOTH_EDGES_EN
  assign evt_set = in_db_reg ^ in_db_dly_reg;
`else
  assign evt_set = in_db_reg & ~in_db_dly_reg;
`endif

  // A set on the same edge as a clear wins, so an edge is never lost.
  assign evt_clr  = (write_enable && hit_evt) ? data_in[NUM_IN-1:0] : '0;
  assign evt_next = (evt_reg & ~evt_clr) | evt_set;

  assign mask_next = (write_enable && hit_mask) ? data_in[NUM_IN-1:0] : mask_reg;

  always_comb begin
    leds_next = leds_reg;
    if (write_enable && hit_out_word) begin
      leds_next = data_in[NUM_OUT-1:0];
    end else if (write_enable) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (led_bit_hit[i]) leds_next[i] = data_in[0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (|in_bit_hit) begin
      rd_data[0] = |(in_bit_hit & in_db_reg);
    end else if (|led_bit_hit) begin
      rd_data[0] = |(led_bit_hit & leds_reg);
    end else if (hit_in_word) begin
      rd_data[NUM_IN-1:0] = in_db_reg;
    end else if (hit_out_word) begin
      rd_data[NUM_OUT-1:0] = leds_reg;
    end else if (hit_evt) begin
      rd_data[NUM_IN-1:0] = evt_reg;
    end else if (hit_mask) begin
      rd_data[NUM_IN-1:0] = mask_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_db_reg     <= '0;
      in_db_dly_reg <= '0;
      evt_reg       <= '0;
      mask_reg      <= '0;
      leds_reg      <= '0;
      data_out_reg  <= '0;
    end else begin
      in_db_reg     <= in_db_next;
      in_db_dly_reg <= in_db_reg;
      evt_reg       <= evt_next;
      mask_reg      <= mask_next;
      leds_reg      <= leds_next;
      data_out_reg  <= rd_data;
    end
  end

  assign data_out = data_out_reg;
  assign leds     = leds_reg;
  assign irq      = |(evt_reg & mask_reg);

endmodule

// File: doc/mmio_gpio_bank.md
# mmio_gpio_bank

Parametrised memory-mapped GPIO peripheral and successor to the bit-per-address button/LED window. It synchronises and debounces `NUM_IN` button inputs, drives `NUM_OUT` LED outputs, latches input edge events into a write-1-to-clear status register and raises a maskable interrupt. It sits on the CPU's word-addressed data bus next to RAM. Reads have one cycle of latency. Writes take effect at the clock edge.

## Interface
- `NUM_IN`, 16: button inputs, 1..16.
- `NUM_OUT`, 16: LED outputs, 1..16.
- `ADDR_W`, 15: bus address width.
- `DEBOUNCE_CYCLES`, 4: stable cycles required before a level is accepted, ≥1. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in `ADDR_W`: word address.
- `write_enable` in 1: write strobe for `addr`/`data_in`.
- `data_in` in 16: write data.
- `data_out` out 16: registered read data.
- `buttons` in `NUM_IN`: raw asynchronous inputs.
- `leds` out `NUM_OUT`: LED register.
- `irq` out 1: level interrupt.

## Operation
- Address map, with `B = NUM_IN + NUM_OUT`:
  - `0..NUM_IN-1`: read `{15'b0, in_db[addr]}`. Writes are ignored.
  - `NUM_IN..B-1`: per-bit LED. A write sets `leds[addr-NUM_IN] <= data_in[0]`. A read returns `{15'b0, leds[addr-NUM_IN]}`.
  - `B+0` IN_WORD: read-only, `in_db` zero-extended.
  - `B+1` OUT_WORD: read/write. The write loads `leds <= data_in[NUM_OUT-1:0]`. Upper bits are ignored and read 0.
  - `B+2` EVT_STATUS: read returns latched events. Writing 1 to a bit clears it.
  - `B+3` IRQ_MASK: read/write, `NUM_IN` bits.
  - All other addresses read 0. Writes to them have no effect.
- Input path, per bit: a 2-flop synchroniser feeds a debounce counter, which feeds `in_db`.
  - While `sync2 == in_db`, the counter is held at 0.
  - While they differ, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, `in_db` takes `sync2` and the counter returns to 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles after sync resets the count and never reaches `in_db`.
- Events: when `in_db[i]` goes 0→1, the block sets `evt[i]`. Other edges depend on configuration (see below).
- `irq = |(evt & mask)`, driven from registers.

## Timing
- Reset (async assert, sync-released by the system): `leds=0`, `data_out=0`, `irq=0`, `evt=0`, `mask=0`, synchronisers=0, `in_db=0`, counters=0.
- Read: `addr` is sampled at edge N and `data_out` is valid after edge N, i.e. 1-cycle latency. `data_out` holds its value until the next edge.
- Write: state updates at the edge where `write_enable=1`. A same-cycle read of that address returns the pre-write value.
- Debounce latency: a level first sampled at edge k and held appears in `in_db` at edge k+1+`DEBOUNCE_CYCLES`. The matching `evt` bit sets one edge later, and `irq` is high in the cycle after that.
- EVT_STATUS collisions:
  - If a set and a W1C clear of the same bit land on the same edge, the set wins and the bit stays 1.
  - Clearing a bit that is not set does nothing.
- A `mask` write takes effect on `irq` in the cycle after the edge.
- Reset mid-debounce discards the count. Buttons held high through reset are re-debounced from 0 and produce a press event after the full latency.

## Configuration
- `MMIO_GPIO_BOTH_EDGES_EN`:
  - Defined: both 0→1 and 1→0 transitions of `in_db[i]` set `evt[i]`.
  - Undefined: only 0→1 (press) sets `evt[i]`, and releases are not recorded.
- Register map and timing are identical in both builds.

## Test plan
- Reset check: hold `rst_n=0` with `buttons=16'hFFFF` → `leds=0`, `data_out=0`, `irq=0`. After release with D=4, `in_db=16'hFFFF` at edge 7 and reading `B+2` returns `16'hFFFF`.
- Glitch filter: pulse `buttons[3]` high for 3 cycles (D=4) → `in_db`, `evt` and `irq` all stay 0. A 10-cycle pulse sets `evt[3]`. The release sets `evt[3]` again only when the macro is defined.
- LED access, writes:
  - Write `16'hA5C3` to `B+1` → `leds=16'hA5C3`.
  - Write 0 to address `NUM_IN+0` → `leds=16'hA5C2`.
- LED access, reads: read `NUM_IN+1` → `data_out=1` one cycle later.
- Interrupt flow:
  - Set `mask=16'h0008` and press button 3 → `irq=1`.
  - Write `16'h0008` to `B+2` → `irq=0` the next cycle.
  - Press button 5 → `irq` stays 0 while EVT_STATUS reads `16'h0020`.
- Collision: W1C of bit 2 on the same edge that `evt[2]` sets → bit 2 reads 1. Writes to `B+4` and beyond change nothing, and those addresses read 0.
